// File: rtl/leaf_bridge_pkg.sv
// Shared types and constants for the leaf_user_bridge slice: start-sequencer
// states, FIFO pointer-width helper and statistics counter width.
package leaf_bridge_pkg;

  localparam int unsigned STAT_BITS = 32;

  typedef enum logic {
    SEQ_WAIT,
    SEQ_RUN
  } seq_state_t;

  // Pointer carries one extra wrap bit so full and empty can be told apart.
  function automatic int unsigned ptr_bits(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/leaf_bridge_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered write-side ready
// and read data forced to zero while empty.
module leaf_bridge_fifo
  import leaf_bridge_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS = 32,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_wr_valid,
  input  logic [PAYLOAD_BITS-1:0] i_wr_data,
  output logic                    o_wr_ready,
  output logic                    o_rd_valid,
  output logic [PAYLOAD_BITS-1:0] o_rd_data,
  input  logic                    i_rd_ready
);

  localparam int unsigned PW = ptr_bits(FIFO_DEPTH);
  localparam int unsigned AW = PW - 1;

  logic [PAYLOAD_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_rd_ptr;
  logic                    r_wr_rdy;
  logic [PW-1:0]           w_wr_ptr_nxt;
  logic [PW-1:0]           w_rd_ptr_nxt;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_full_nxt;

  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_push       = i_wr_valid & r_wr_rdy;
  assign w_pop        = i_rd_ready & ~w_empty;
  assign w_wr_ptr_nxt = r_wr_ptr + PW'(w_push);
  assign w_rd_ptr_nxt = r_rd_ptr + PW'(w_pop);
  assign w_full_nxt   = ((w_wr_ptr_nxt ^ w_rd_ptr_nxt) == {1'b1, {AW{1'b0}}});

  // Ready is precomputed from the next pointer state, so it stays low during
  // reset and a pop out of full only re-opens the write side one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_wr_rdy <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_wr_rdy <= ~w_full_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

  assign o_wr_ready = r_wr_rdy;
  assign o_rd_valid = ~w_empty;
  assign o_rd_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/leaf_user_bridge.sv
// Elastic bridge between leaf_interface user ports and an AXI-Stream HLS kernel,
// with a post-reset ap_start sequencer. Optional counters: LEAF_BRIDGE_STATS_EN.
module leaf_user_bridge
  import leaf_bridge_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS  = 32,
  parameter int unsigned NUM_IN_PORTS  = 1,
  parameter int unsigned NUM_OUT_PORTS = 1,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned START_DELAY   = 8
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]   dout_leaf_interface2user,
  input  logic [NUM_IN_PORTS-1:0]                vld_interface2user,
  output logic [NUM_IN_PORTS-1:0]                ack_user2interface,
  output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]  din_leaf_user2interface,
  output logic [NUM_OUT_PORTS-1:0]               vld_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]               ack_interface2user,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]   in_tdata,
  output logic [NUM_IN_PORTS-1:0]                in_tvalid,
  input  logic [NUM_IN_PORTS-1:0]                in_tready,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]  out_tdata,
  input  logic [NUM_OUT_PORTS-1:0]               out_tvalid,
  output logic [NUM_OUT_PORTS-1:0]               out_tready,
  output logic                                   ap_start,
  input  logic                                   clr_stats
`ifdef LEAF_BRIDGE_STATS_EN
  ,
  output logic [STAT_BITS*NUM_IN_PORTS-1:0]      stat_in_cnt,
  output logic [STAT_BITS*NUM_OUT_PORTS-1:0]     stat_out_cnt
`endif
);

  seq_state_t r_state;
  logic [7:0] r_dly_cnt;
  logic       r_ap_start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= SEQ_WAIT;
      r_dly_cnt  <= '0;
      r_ap_start <= 1'b0;
    end else begin
      case (r_state)
        SEQ_WAIT: begin
          if (r_dly_cnt == 8'(START_DELAY)) begin
            r_state    <= SEQ_RUN;
            r_ap_start <= 1'b1;
          end else begin
            r_dly_cnt <= r_dly_cnt + 8'd1;
          end
        end
        SEQ_RUN: r_ap_start <= 1'b1;
        default: r_state <= SEQ_WAIT;
      endcase
    end
  end

  assign ap_start = r_ap_start;

  // Input channels only accept words once the kernel has been started.
  for (genvar gi = 0; gi < NUM_IN_PORTS; gi++) begin : g_in
    logic w_wr_vld;
    logic w_wr_rdy;

    assign w_wr_vld = vld_interface2user[gi] & r_ap_start;
    assign ack_user2interface[gi] = w_wr_rdy & r_ap_start;

    leaf_bridge_fifo #(
      .PAYLOAD_BITS(PAYLOAD_BITS),
      .FIFO_DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_wr_valid(w_wr_vld),
      .i_wr_data (dout_leaf_interface2user[gi*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .o_wr_ready(w_wr_rdy),
      .o_rd_valid(in_tvalid[gi]),
      .o_rd_data (in_tdata[gi*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .i_rd_ready(in_tready[gi])
    );
  end

  for (genvar go = 0; go < NUM_OUT_PORTS; go++) begin : g_out
    leaf_bridge_fifo #(
      .PAYLOAD_BITS(PAYLOAD_BITS),
      .FIFO_DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_wr_valid(out_tvalid[go]),
      .i_wr_data (out_tdata[go*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .o_wr_ready(out_tready[go]),
      .o_rd_valid(vld_user2interface[go]),
      .o_rd_data (din_leaf_user2interface[go*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .i_rd_ready(ack_interface2user[go])
    );
  end

`ifdef LEAF_BRIDGE_STATS_EN
  logic [NUM_IN_PORTS-1:0][STAT_BITS-1:0]  r_stat_in;
  logic [NUM_OUT_PORTS-1:0][STAT_BITS-1:0] r_stat_out;
  logic [NUM_IN_PORTS-1:0]                 w_in_xfer;
  logic [NUM_OUT_PORTS-1:0]                w_out_xfer;

  assign w_in_xfer  = vld_interface2user & ack_user2interface;
  assign w_out_xfer = vld_user2interface & ack_interface2user;

  // Clear takes priority over a coincident transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_in  <= '0;
      r_stat_out <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_IN_PORTS; i++) begin
        if (clr_stats) begin
          r_stat_in[i] <= '0;
        end else if (w_in_xfer[i]) begin
          r_stat_in[i] <= r_stat_in[i] + STAT_BITS'(1);
        end
      end
      for (int unsigned j = 0; j < NUM_OUT_PORTS; j++) begin
        if (clr_stats) begin
          r_stat_out[j] <= '0;
        end else if (w_out_xfer[j]) begin
          r_stat_out[j] <= r_stat_out[j] + STAT_BITS'(1);
        end
      end
    end
  end

  assign stat_in_cnt  = r_stat_in;
  assign stat_out_cnt = r_stat_out;
`else
  logic w_unused_clr;
  assign w_unused_clr = clr_stats;
`endif

endmodule

// File: doc/leaf_user_bridge.md
# leaf_user_bridge

Parametrised elastic bridge between the leaf_interface user-side ports and a streaming HLS kernel in a page leaf. For each input and output channel it adds a first-word-fall-through FIFO that converts the leaf vld/ack handshake to AXI-Stream TVALID/TREADY and absorbs kernel back-pressure. It also generates the kernel's ap_start from a post-reset start sequencer. It replaces hand-wired one-port leaves with a single instance that scales in channel count, payload width and buffer depth.

## Interface
- PAYLOAD_BITS, 32, data width per channel.
- NUM_IN_PORTS, 1, interface-to-kernel channels (1..8).
- NUM_OUT_PORTS, 1, kernel-to-interface channels (1..8).
- FIFO_DEPTH, 4, entries per channel FIFO; power of two, 2..64.
- START_DELAY, 8, cycles after reset release before ap_start rises (0..255).

- clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- dout_leaf_interface2user  in  NUM_IN_PORTS*PAYLOAD_BITS  data from leaf_interface, channel i at bits [i*PAYLOAD_BITS +: PAYLOAD_BITS]
- vld_interface2user  in  NUM_IN_PORTS  per-channel valid from leaf_interface
- ack_user2interface  out  NUM_IN_PORTS  per-channel ready to leaf_interface
- din_leaf_user2interface  out  NUM_OUT_PORTS*PAYLOAD_BITS  data to leaf_interface
- vld_user2interface  out  NUM_OUT_PORTS  per-channel valid to leaf_interface
- ack_interface2user  in  NUM_OUT_PORTS  per-channel ready from leaf_interface
- in_tdata / in_tvalid / in_tready  out/out/in  NUM_IN_PORTS*PAYLOAD_BITS / NUM_IN_PORTS / NUM_IN_PORTS  kernel input streams
- out_tdata / out_tvalid / out_tready  in/in/out  NUM_OUT_PORTS*PAYLOAD_BITS / NUM_OUT_PORTS / NUM_OUT_PORTS  kernel output streams
- ap_start  out  1  kernel start
- clr_stats  in  1  synchronous clear of statistics (used only with LEAF_BRIDGE_STATS_EN)
- stat_in_cnt / stat_out_cnt  out  32*NUM_IN_PORTS / 32*NUM_OUT_PORTS  per-channel word counters (present only with LEAF_BRIDGE_STATS_EN)

## Operation
- A transfer occurs on any side in a cycle where valid and ready are both high. vld/ack are treated exactly as TVALID/TREADY.
- Each channel has an independent FIFO of FIFO_DEPTH entries. Read and write pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH. Full is when the pointers differ only in the MSB; empty is when they are equal.
- Write-side ready = !full, registered from the pointer state. Ready never depends combinationally on the downstream ready.
- Read-side valid = !empty. Read data is the head entry, stable while valid is high and ready is low.
- Simultaneous push and pop when the FIFO is neither full nor empty: occupancy is unchanged and both are accepted.
- Full: the push is refused (ready low) even if a pop occurs in the same cycle, and ready rises the next cycle.
- Empty: a push in that cycle is not visible on the read side until the next cycle.
- Start sequencer states:
  - WAIT: count from 0 up to START_DELAY.
  - RUN: ap_start=1 permanently.
  - START_DELAY=0 goes to RUN on the first clock after reset release.
  - Write-side ready on every input-channel FIFO is forced low in WAIT.
- Reset asserted mid-operation: all pointers clear, FIFO contents are discarded, the sequencer returns to WAIT, and the outputs below take their reset values asynchronously.

## Timing
- Reset values: all ack_user2interface=0, in_tvalid=0, vld_user2interface=0, out_tready=0, ap_start=0, tdata outputs=0, counters=0.
- out_tready rises 1 cycle after reset release. ack_user2interface rises in the cycle ap_start rises.
- Latency is 1 cycle from an accepted push to read-side valid, and 0 cycles from a pop to the next head word.
- Throughput is one word per cycle per channel when the FIFO is neither full nor empty.
- ap_start rises START_DELAY+1 clock edges after reset_n deasserts.

## Configuration
- LEAF_BRIDGE_STATS_EN defined:
  - Per-channel 32-bit counters increment on each transfer at the leaf_interface side of that channel.
  - Counters wrap at 2^32.
  - clr_stats zeroes all counters next cycle. If clr_stats and a transfer coincide, the counter reads 0.
- LEAF_BRIDGE_STATS_EN undefined: the stat ports and counters are absent, clr_stats is ignored, and no statistics logic is synthesised.

## Structure
- Package leaf_bridge_pkg holds:
  - the start-sequencer state enum (WAIT, RUN);
  - the function clog2-based pointer-width helper;
  - the constant STAT_BITS=32.
- Sub-module leaf_bridge_fifo: one single-clock FWFT FIFO with PAYLOAD_BITS and FIFO_DEPTH parameters. It is instantiated NUM_IN_PORTS+NUM_OUT_PORTS times via generate.

## Test plan
- Reset release with START_DELAY=8: ap_start low for 8 cycles and high from edge 9. No ack_user2interface before then, and a pending vld is not accepted until then.
- Fill the channel 0 input FIFO with FIFO_DEPTH=4 and in_tready=0: words 0x11..0x44 accepted and ack drops. A 5th word is held. On releasing in_tready, 0x11..0x44 then the 5th word arrive in order, one per cycle.
- Full FIFO with simultaneous pop and push attempt: the pop succeeds, the push is refused that cycle and accepted the next cycle.
- With NUM_IN_PORTS=2 and NUM_OUT_PORTS=3: an independent pattern per channel with random back-pressure. No cross-channel data, no loss or duplication, and correct bit slicing on the flattened buses.
- Assert reset_n low while 3 words are buffered: all valids are 0 immediately, and after release the FIFOs are empty with no stale words emitted.
- With LEAF_BRIDGE_STATS_EN: send 1000 words on out channel 1 and check stat_out_cnt[1]=1000. Pulse clr_stats concurrently with a transfer and check the counter reads 0.
